// File: rtl/tick_scheduler_pkg.sv
// rtl/tick_scheduler_pkg.sv - shared state encoding and defaults for the tick scheduler
package tick_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

    localparam int CW_DEFAULT = 16;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one divided clock-enable channel with shadowed divisor/enable config
module tick_channel
    import tick_scheduler_pkg::*;
#(
    parameter int             CW      = CW_DEFAULT,
    parameter logic [CW-1:0]  DEF_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    input  logic          wr_en,
    input  logic          step,
    input  logic          clear,
    input  logic          resync,
    input  logic          idle,
    input  logic          idle_next,
    output logic          tick,
    output logic          phase,
    output logic          apply
);

    logic [CW-1:0] div, sh_div, cnt;
    logic          en, sh_en, pending;

    logic          active, wrap, pend_nxt, sh_en_nxt, en_nxt, phase_nxt;
    logic [CW-1:0] sh_div_nxt, div_nxt, cnt_nxt;

    always_comb begin
        active     = en && (div != '0);
        wrap       = step && active && !clear && (cnt == div - 1'b1);
        pend_nxt   = wr || pending;
        sh_div_nxt = wr ? wr_div : sh_div;
        sh_en_nxt  = wr ? wr_en : sh_en;
        // A silent channel has no period to finish, so its config lands at once.
        apply      = pend_nxt && (resync || idle || !active || wrap);
        div_nxt    = apply ? sh_div_nxt : div;
        en_nxt     = apply ? sh_en_nxt : en;
        cnt_nxt    = cnt;
        if (clear || wrap) begin
            cnt_nxt = '0;
        end else if (step && active) begin
            cnt_nxt = cnt + 1'b1;
        end
        phase_nxt  = !idle_next && en_nxt && (div_nxt != '0) && (cnt_nxt < (div_nxt >> 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= DEF_DIV;
            en      <= 1'b0;
            sh_div  <= DEF_DIV;
            sh_en   <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
            tick    <= 1'b0;
            phase   <= 1'b0;
        end else begin
            div     <= div_nxt;
            en      <= en_nxt;
            sh_div  <= sh_div_nxt;
            sh_en   <= sh_en_nxt;
            pending <= pend_nxt && !apply;
            cnt     <= cnt_nxt;
            tick    <= wrap;
            phase   <= phase_nxt;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shared prescaler, run/hold FSM and NCH programmable tick channels
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int             NCH     = 4,
    parameter logic [15:0]    PRE_DIV = 16'd100,
    parameter int             CW      = CW_DEFAULT,
    parameter logic [CW-1:0]  DEF_DIV = 2,
    localparam int            SW      = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           resync,
    input  logic           cfg_we,
    input  logic [SW-1:0]  cfg_sel,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic           cfg_ack,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] phase,
    output logic           running
);

    sched_state_e state, state_nxt;
    logic [15:0]  pre_cnt;
    logic [31:0]  sel_ext;
    logic [NCH-1:0] apply_vec;
    logic         run_adv, enter_idle, clear, pre_wrap;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!stop && start) state_nxt = ST_RUN;
            ST_RUN:  if (stop) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (stop) state_nxt = ST_IDLE;
                else if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The prescaler only counts cycles that stay in RUN, so base_tick never lands in HOLD.
    assign run_adv    = (state == ST_RUN) && !stop;
    assign enter_idle = (state == ST_HOLD) && stop;
    assign clear      = resync || enter_idle;
    assign pre_wrap   = (pre_cnt == PRE_DIV - 16'd1);
    assign sel_ext    = 32'(cfg_sel);
    assign running    = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pre_cnt   <= '0;
            base_tick <= 1'b0;
            cfg_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            base_tick <= run_adv && pre_wrap && !resync;
            cfg_ack   <= |apply_vec;
            if (clear) begin
                pre_cnt <= '0;
            end else if (run_adv) begin
                pre_cnt <= pre_wrap ? 16'd0 : pre_cnt + 16'd1;
            end
        end
    end

    // Out-of-range cfg_sel matches no channel and is silently dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_channel #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr        (cfg_we && (sel_ext == g)),
            .wr_div    (cfg_div),
            .wr_en     (cfg_en),
            .step      (base_tick),
            .clear     (clear),
            .resync    (resync),
            .idle      (state == ST_IDLE),
            .idle_next (state_nxt == ST_IDLE),
            .tick      (tick[g]),
            .phase     (phase[g]),
            .apply     (apply_vec[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized scoreboard bench for tick_scheduler against a behavioural model
module tb_tick_scheduler;

    localparam int NCH = 3;
    localparam int PD  = 4;
    localparam int DEF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, stop = 1'b0, resync = 1'b0;
    logic       cfg_we = 1'b0, cfg_en = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ack, base_tick, running;
    logic [2:0] tick, phase;

    tick_scheduler #(
        .NCH     (NCH),
        .PRE_DIV (16'd4),
        .CW      (8),
        .DEF_DIV (8'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .resync    (resync),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_ack   (cfg_ack),
        .base_tick (base_tick),
        .tick      (tick),
        .phase     (phase),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [8:0] exp;
    } item_t;

    item_t sbq[$];
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model mode: 0 idle, 1 run, 2 hold. Counts are in base ticks / run cycles.
    int       m_mode, m_runs;
    int       m_pos[NCH], m_div[NCH], m_new_div[NCH];
    bit       m_en[NCH], m_new_en[NCH], m_pend[NCH];
    bit       m_bt, m_ack;
    bit [2:0] m_tick, m_phase;

    function automatic logic [8:0] model_out();
        return {m_ack, m_bt, m_tick, m_phase, (m_mode == 1)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_runs = 0; m_bt = 0; m_ack = 0; m_tick = '0; m_phase = '0;
        for (int i = 0; i < NCH; i++) begin
            m_pos[i] = 0; m_div[i] = DEF; m_en[i] = 0;
            m_new_div[i] = DEF; m_new_en[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit p, input bit y,
                              input bit w, input int sel, input int d, input bit e);
        int  next_mode;
        bit  counting, zeroing, live, period_done, bt_prev;
        if (r) begin
            model_reset();
            return;
        end
        next_mode = m_mode;
        if (p) next_mode = (m_mode == 1) ? 2 : 0;
        else if (s) next_mode = 1;
        counting = (m_mode == 1) && !p;
        zeroing  = y || (m_mode == 2 && p);
        bt_prev  = m_bt;
        m_ack    = 0;
        for (int i = 0; i < NCH; i++) begin
            live = m_en[i] && (m_div[i] != 0);
            period_done = bt_prev && live && !zeroing && (m_pos[i] + 1 == m_div[i]);
            if (w && sel == i) begin
                m_new_div[i] = d; m_new_en[i] = e; m_pend[i] = 1;
            end
            if (zeroing || period_done) m_pos[i] = 0;
            else if (bt_prev && live) m_pos[i] = m_pos[i] + 1;
            m_tick[i] = period_done;
            if (m_pend[i] && (y || m_mode == 0 || !live || period_done)) begin
                m_div[i] = m_new_div[i]; m_en[i] = m_new_en[i]; m_pend[i] = 0;
                m_ack = 1;
            end
            m_phase[i] = (next_mode != 0) && m_en[i] && (m_div[i] != 0) && (m_pos[i] < m_div[i] / 2);
        end
        if (zeroing) begin
            m_runs = 0;
            m_bt = 0;
        end else if (counting) begin
            m_runs = m_runs + 1;
            m_bt = (m_runs % PD == 0);
        end else begin
            m_bt = 0;
        end
        m_mode = next_mode;
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit y,
                         input bit w, input int sel, input int d, input bit e);
        item_t it;
        @(posedge clk);
        #1;
        rst = r; start = s; stop = p; resync = y;
        cfg_we = w; cfg_sel = sel[1:0]; cfg_div = d[7:0]; cfg_en = e;
        model_step(r, s, p, y, w, sel, d, e);
        it.due = cyc + 1;
        it.exp = model_out();
        sbq.push_back(it);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin : monitor
        item_t      it;
        logic [8:0] got;
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            it  = sbq.pop_front();
            got = {cfg_ack, base_tick, tick, phase, running};
            compared++;
            if (it.due != cyc || got !== it.exp) begin
                mismatched++;
                $display("FAIL outputs edge %0d (due %0d): got %b required %b [ack,base,tick2..0,phase2..0,run]",
                         cyc, it.due, got, it.exp);
            end
        end
    end

    initial begin
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle_cycles(14);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 3, 1);
        drive(0, 0, 0, 0, 1, 1, 2, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle_cycles(30);
        drive(0, 0, 0, 0, 1, 1, 5, 1);
        idle_cycles(2);
        drive(0, 0, 0, 0, 1, 1, 5, 1);
        idle_cycles(60);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle_cycles(10);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle_cycles(25);
        drive(0, 0, 0, 0, 1, 0, 4, 1);
        idle_cycles(7);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle_cycles(10);
        drive(0, 0, 0, 0, 1, 2, 0, 1);
        drive(0, 0, 0, 0, 1, 3, 6, 1);
        idle_cycles(20);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle_cycles(3);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        idle_cycles(3);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 3, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);
        for (int k = 0; k < 4000; k++) begin
            drive($urandom_range(0, 999) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 11) == 0,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 6)),
                  $urandom_range(0, 5) != 0);
        end
        idle_cycles(2);
        repeat (3) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected responses never checked, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
